// File: rtl/seg_feeder_pkg.sv
// Shared types and defaults for the segment feeder.
// State encodings, default field widths and the segment record width.
package seg_feeder_pkg;

  localparam int SEG_W_DEF      = 32;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  function automatic int seg_rec_w(input int seg_w);
    return 2 * seg_w;
  endfunction

endpackage

// File: rtl/seg_feeder_if.sv
// Host write port and generator hand-off signals of the segment feeder.
// master = host/command decoder + step generator side, slave = feeder.
interface seg_feeder_if
  import seg_feeder_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) ();

  logic [SEG_W-1:0] wr_dt;
  logic [SEG_W-1:0] wr_steps;
  logic             wr_stb;
  logic             full;
  logic             empty;
  logic             gen_done;
  logic             gen_abort;
  logic [SEG_W-1:0] dt_val;
  logic [SEG_W-1:0] steps_val;
  logic             load;

  modport slave (
    input  wr_dt, wr_steps, wr_stb, gen_done, gen_abort,
    output full, empty, dt_val, steps_val, load
  );

  modport master (
    output wr_dt, wr_steps, wr_stb, gen_done, gen_abort,
    input  full, empty, dt_val, steps_val, load
  );

endinterface

// File: rtl/seg_fifo.sv
// First-word-fall-through segment FIFO with wrap-bit pointers.
// SEG_FEEDER_LEVEL_EN adds a registered occupancy output o_level.
module seg_fifo
  import seg_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int W          = seg_rec_w(SEG_W_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_din,
  output logic [W-1:0]          o_dout,
  output logic                  o_full,
  output logic                  o_empty
`ifdef SEG_FEEDER_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   o_level
`endif
);

  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [W-1:0]          r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Wrap bits differ with equal index bits means the writer lapped the reader.
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

`ifdef SEG_FEEDER_LEVEL_EN
  logic [DEPTH_LOG2:0] r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + PTR_ONE;
        2'b01:   r_level <= r_level - PTR_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_level = r_level;
`endif

endmodule

// File: rtl/seg_feeder.sv
// Segment queue feeding {dt, steps} to the step generator, refilled on gen_done.
// SEG_FEEDER_LEVEL_EN adds the FIFO occupancy output port level.
//
// state   | meaning
// S_IDLE  | no segment issued yet; waits for enable and data
// S_RUN   | generator executing a segment; refill on gen_done
// S_DRAIN | generator finished and waiting; load as soon as data arrives
// S_HALT  | generator aborted; no loads until clear_underrun
module seg_feeder
  import seg_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int SEG_W      = SEG_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  seg_feeder_if.slave         bus,
  output logic                busy,
  output logic                underrun,
  input  logic                clear_underrun,
  output logic                wr_err
`ifdef SEG_FEEDER_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int REC_W = seg_rec_w(SEG_W);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_pop;
  logic               w_set_uf;
  logic               w_push;
  logic               w_wr_rej;
  logic               w_full;
  logic               w_empty;
  logic [REC_W-1:0]   w_head;
  logic [SEG_W-1:0]   r_dt_val;
  logic [SEG_W-1:0]   r_steps_val;
  logic               r_load;
  logic               r_underrun;
  logic               r_wr_err;

  // Zero-length or zero-interval segments would stall the generator, so reject them.
  assign w_push   = bus.wr_stb && !w_full && (bus.wr_dt != '0) && (bus.wr_steps != '0);
  assign w_wr_rej = bus.wr_stb && !w_push;

  seg_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .W         (REC_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  ({bus.wr_dt, bus.wr_steps}),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
`ifdef SEG_FEEDER_LEVEL_EN
    ,
    .o_level(level)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_set_uf    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.gen_abort) begin
          w_set_uf    = 1'b1;
          w_state_nxt = S_HALT;
        end else if (bus.gen_done) begin
          if (enable && !w_empty) w_pop = 1'b1;
          else                    w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.gen_abort) begin
          w_set_uf    = 1'b1;
          w_state_nxt = S_HALT;
        end else if (enable && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        if (clear_underrun) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dt_val    <= '0;
      r_steps_val <= '0;
      r_load      <= 1'b0;
      r_underrun  <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_pop;
      if (w_pop) begin
        r_dt_val    <= w_head[REC_W-1:SEG_W];
        r_steps_val <= w_head[SEG_W-1:0];
      end
      // A new event in the same cycle as the clear wins, so it is not lost.
      if (w_set_uf)            r_underrun <= 1'b1;
      else if (clear_underrun) r_underrun <= 1'b0;
      if (w_wr_rej)            r_wr_err   <= 1'b1;
      else if (clear_underrun) r_wr_err   <= 1'b0;
    end
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.dt_val    = r_dt_val;
  assign bus.steps_val = r_steps_val;
  assign bus.load      = r_load;
  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign underrun      = r_underrun;
  assign wr_err        = r_wr_err;

endmodule
